mem_data_ctrl: RTL and testbench

Parametrised single-port data memory for the MEM stage, generalising the existing 2048x32 data RAM.
- Adds configurable width, depth and wait states, byte-lane writes, synchronous reset, a busy flag and an explicit FSM-driven rdy handshake.
- `data_out` holds the last read value; it is never tri-stated.
- Sits between the MEM-stage load/store logic and the register write-back path.

---
 rtl/mem_data_ctrl_if.sv | 25 ++
 rtl/mem_data_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_data_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_data_ctrl_if.sv
// Request/response bundle between MEM-stage load/store logic and the data memory controller.
interface mem_data_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W/8-1:0] byte_en;
  logic                memRead;
  logic                memWrite;
  logic [DATA_W-1:0]   data_out;
  logic                rdy;
  logic                busy;
  logic                err;

  modport master (
    output addr, data_in, byte_en, memRead, memWrite,
    input  data_out, rdy, busy, err
  );

  modport slave (
    input  addr, data_in, byte_en, memRead, memWrite,
    output data_out, rdy, busy, err
  );
endinterface

// File: rtl/mem_data_ctrl.sv
// Parametrised single-port MEM-stage data memory with wait states, byte lanes and rdy handshake.
// Optional range-error flag built when MEM_RANGE_CHECK_EN is defined.
module mem_data_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst,
  mem_data_ctrl_if.slave bus
);
  localparam int LANES   = DATA_W / 8;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, do_access;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [LANES-1:0]  be_q;
  logic              rd_q, wr_q;

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_din;
  logic [LANES-1:0]  acc_be;
  logic              acc_rd, acc_wr;
  logic              in_range;
  logic [IDX_W-1:0]  acc_idx;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        state_nxt = S_IDLE;
        if (bus.memRead || bus.memWrite) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            state_nxt = S_RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          do_access = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Without wait states the access happens on the accept edge, straight from the bus.
  always_comb begin
    acc_addr = NO_WAIT ? bus.addr     : addr_q;
    acc_din  = NO_WAIT ? bus.data_in  : din_q;
    acc_be   = NO_WAIT ? bus.byte_en  : be_q;
    acc_rd   = NO_WAIT ? bus.memRead  : rd_q;
    acc_wr   = NO_WAIT ? bus.memWrite : wr_q;
    in_range = ({1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH));
    acc_idx  = acc_addr[IDX_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Reads the pre-write word, giving read-before-write on a combined request.
      if (do_access && acc_rd)
        data_q <= in_range ? mem[acc_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= bus.addr;
      din_q  <= bus.data_in;
      be_q   <= bus.byte_en;
      rd_q   <= bus.memRead;
      wr_q   <= bus.memWrite;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; rst only gates a pending write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_wr && in_range) begin
      for (int i = 0; i < LANES; i++)
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_din[8*i +: 8];
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= do_access && !in_range;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.data_out = data_q;
  assign bus.rdy      = (state == S_RESP);
  assign bus.busy     = (state == S_WAIT);
endmodule

// File: tb/tb_mem_data_ctrl.sv
// Scoreboard bench: a zero-wait DUT (DEPTH=1000) and a 3-wait-state DUT (DEPTH=2048).
module tb_mem_data_ctrl;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MEM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  mem_data_ctrl_if #(.DATA_W(32), .ADDR_W(11)) bus_a ();
  mem_data_ctrl_if #(.DATA_W(32), .ADDR_W(11)) bus_b ();

  mem_data_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(1000), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  mem_data_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(2048), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per rdy pulse.
  always @(negedge clk) begin
    if (bus_a.rdy) begin
      if (q_a.size() == 0) check("a_spurious_rdy", bus_a.rdy, 1'b0);
      else begin
        ea = q_a.pop_front();
        check("a_data_out", bus_a.data_out, ea.data);
        check("a_err", bus_a.err, ea.err);
        check("a_rdy_cycle", cyc, ea.cyc);
      end
    end else check("a_err_idle", bus_a.err, 1'b0);
  end

  always @(negedge clk) begin
    if (bus_b.rdy) begin
      if (q_b.size() == 0) check("b_spurious_rdy", bus_b.rdy, 1'b0);
      else begin
        eb = q_b.pop_front();
        check("b_data_out", bus_b.data_out, eb.data);
        check("b_err", bus_b.err, eb.err);
        check("b_rdy_cycle", cyc, eb.cyc);
      end
    end else check("b_err_idle", bus_b.err, 1'b0);
  end

  task automatic drive_a(input logic rd, input logic wr, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    bus_a.memRead = rd; bus_a.memWrite = wr; bus_a.addr = a;
    bus_a.data_in = d;  bus_a.byte_en = be;
  endtask

  task automatic drive_b(input logic rd, input logic wr, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    bus_b.memRead = rd; bus_b.memWrite = wr; bus_b.addr = a;
    bus_b.data_in = d;  bus_b.byte_en = be;
  endtask

  // Called at a negedge; request held for exactly one edge, back-to-back calls allowed.
  task automatic req_a(input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_data, input logic exp_err);
    q_a.push_back('{exp_data, exp_err, cyc + 1});
    drive_a(rd, wr, a, d, be);
    @(negedge clk);
  endtask

  // Returns at the negedge where rdy is visible (DUT in RESP).
  task automatic req_b(input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_data, input logic exp_err);
    q_b.push_back('{exp_data, exp_err, cyc + 4});
    drive_b(rd, wr, a, d, be);
    @(negedge clk);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);

    check("a_reset_data_out", bus_a.data_out, 32'h0);
    check("a_reset_rdy", bus_a.rdy, 1'b0);
    check("a_reset_busy", bus_a.busy, 1'b0);
    check("b_reset_data_out", bus_b.data_out, 32'h0);
    check("b_reset_rdy", bus_b.rdy, 1'b0);
    check("b_reset_busy", bus_b.busy, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Zero-wait DUT, back-to-back traffic.
    req_a(1'b0, 1'b1, 11'd5,    32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0);
    req_a(1'b1, 1'b0, 11'd5,    32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    req_a(1'b0, 1'b1, 11'd7,    32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0);
    req_a(1'b0, 1'b1, 11'd7,    32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0);
    req_a(1'b1, 1'b0, 11'd7,    32'h0,        4'h0, 32'h11BB33DD, 1'b0);
    req_a(1'b0, 1'b1, 11'd9,    32'h00000001, 4'hF, 32'h11BB33DD, 1'b0);
    req_a(1'b1, 1'b1, 11'd9,    32'h00000002, 4'hF, 32'h00000001, 1'b0);
    req_a(1'b1, 1'b0, 11'd9,    32'h0,        4'h0, 32'h00000002, 1'b0);
    req_a(1'b0, 1'b1, 11'd9,    32'hFFFFFFFF, 4'h0, 32'h00000002, 1'b0);
    req_a(1'b1, 1'b0, 11'd9,    32'h0,        4'h0, 32'h00000002, 1'b0);
    req_a(1'b0, 1'b1, 11'd999,  32'h12345678, 4'hF, 32'h00000002, 1'b0);
    req_a(1'b1, 1'b0, 11'd999,  32'h0,        4'h0, 32'h12345678, 1'b0);
    req_a(1'b1, 1'b0, 11'd1500, 32'h0,        4'h0, 32'h00000000, RC);
    req_a(1'b0, 1'b1, 11'd1029, 32'hFFFFFFFF, 4'hF, 32'h00000000, RC);
    req_a(1'b1, 1'b0, 11'd1000, 32'h0,        4'h0, 32'h00000000, RC);
    req_a(1'b1, 1'b0, 11'd5,    32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    drive_a(1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    req_a(1'b1, 1'b0, 11'd7,    32'h0,        4'h0, 32'h11BB33DD, 1'b0);
    drive_a(1'b0, 1'b0, '0, '0, '0);

    // Three-wait-state DUT.
    req_b(1'b0, 1'b1, 11'd20, 32'hCAFE0001, 4'hF, 32'h00000000, 1'b0);
    req_b(1'b0, 1'b1, 11'd3,  32'h00000000, 4'hF, 32'h00000000, 1'b0);

    // Read with a write pulse during WAIT that must be ignored.
    q_b.push_back('{32'hCAFE0001, 1'b0, cyc + 4});
    drive_b(1'b1, 1'b0, 11'd20, 32'h0, 4'h0);
    @(negedge clk);
    check("b_busy_wait1", bus_b.busy, 1'b1);
    check("b_rdy_wait1", bus_b.rdy, 1'b0);
    drive_b(1'b0, 1'b1, 11'd20, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    check("b_busy_wait2", bus_b.busy, 1'b1);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("b_busy_wait3", bus_b.busy, 1'b1);
    check("b_rdy_wait3", bus_b.rdy, 1'b0);
    @(negedge clk);
    check("b_busy_done", bus_b.busy, 1'b0);
    req_b(1'b1, 1'b0, 11'd20, 32'h0, 4'h0, 32'hCAFE0001, 1'b0);

    // Reset on the second WAIT edge aborts the write to addr 3.
    drive_b(1'b0, 1'b1, 11'd3, 32'h55AA55AA, 4'hF);
    @(negedge clk);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_abort_busy", bus_b.busy, 1'b0);
    check("b_abort_rdy", bus_b.rdy, 1'b0);
    check("b_abort_data_out", bus_b.data_out, 32'h0);
    repeat (3) @(negedge clk);
    req_b(1'b1, 1'b0, 11'd3, 32'h0, 4'h0, 32'h00000000, 1'b0);

    repeat (4) @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
